// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
//   Parametrised single-clock FIFO. DEPTH = 2**ADDR_W entries of DATA_W bits.
//   The read side is either registered (FWFT=0) or first-word-fall-through
//   (FWFT=1). A full FIFO accepts a push in the same cycle as an accepted pop.
//   clr is a synchronous flush. overflow and underflow are sticky error flags.
//
// Handshake: push and pop are requests that are qualified internally.
//   A push is taken when the FIFO is not full, or when a pop is taken in the
//   same cycle. A pop is taken when the FIFO is not empty. A rejected request
//   leaves no trace except the matching sticky error flag.
//   FWFT=0: dout_valid pulses for one cycle, the cycle after a pop is taken,
//           and dout then holds the popped word.
//   FWFT=1: dout_valid equals !empty, and dout shows the oldest word.
//
// Ports
//   clk, rst       clock (rising edge); reset (asynchronous, active-high)
//   clr            synchronous flush, takes priority over push/pop
//   push, din      write request and write data
//   pop            read request
//   dout           read data
//   dout_valid     read data qualifier (see above)
//   empty, full    count == 0 / count == DEPTH
//   almost_empty   count <= AE_LEVEL
//   almost_full    count >= AF_LEVEL
//   count          occupancy, 0..DEPTH
//   overflow       sticky: a push was rejected
//   underflow      sticky: a pop was rejected
// -----------------------------------------------------------------------------
module sync_fifo_param #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] AF_C    = AF_LEVEL[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_C    = AE_LEVEL[ADDR_W:0];

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_q;
    logic              pop_ok;
    logic              push_ok;

    // Flags decode straight from the registered count.
    assign count        = count_q;
    assign empty        = (count_q == '0);
    assign full         = (count_q == DEPTH_C);
    assign almost_empty = (count_q <= AE_C);
    assign almost_full  = (count_q >= AF_C);

    assign pop_ok  = pop & ~empty;
    // A full FIFO frees a slot in the same cycle when a pop is taken.
    assign push_ok = push & (~full | pop_ok);

    // Pointers and occupancy. Pointers wrap modulo DEPTH by overflowing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; occupancy alone says what is valid.
    always_ff @(posedge clk) begin
        if (push_ok && !clr) begin
            mem[wr_ptr] <= din;
        end
    end

    // Sticky error flags, cleared only by rst or clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end
            if (pop && !pop_ok) begin
                underflow <= 1'b1;
            end
        end
    end

    generate
        if (FWFT == 0) begin : g_reg_read
            logic [DATA_W-1:0] dout_q;
            logic              dout_valid_q;

            // When full, a same-cycle push to rd_ptr lands after this read,
            // so the popped word is the old contents (read-before-write).
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dout_q       <= '0;
                    dout_valid_q <= 1'b0;
                end else if (clr) begin
                    dout_valid_q <= 1'b0;
                end else if (pop_ok) begin
                    dout_q       <= mem[rd_ptr];
                    dout_valid_q <= 1'b1;
                end else begin
                    dout_valid_q <= 1'b0;
                end
            end

            assign dout       = dout_q;
            assign dout_valid = dout_valid_q;
        end else begin : g_fwft_read
            assign dout       = mem[rd_ptr];
            assign dout_valid = ~empty;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_param
//   Two FIFOs share one stimulus stream: one in registered-read mode, one in
//   FWFT mode. A queue-based reference model predicts occupancy, flags and
//   read data from the FIFO rules; every output is compared after each clock.
// -----------------------------------------------------------------------------
module tb_sync_fifo_param;

    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 3;
    localparam int DEPTH    = 1 << ADDR_W;
    localparam int AF_LEVEL = 6;
    localparam int AE_LEVEL = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              clr  = 1'b0;
    logic              push = 1'b0;
    logic              pop  = 1'b0;
    logic [DATA_W-1:0] din  = '0;

    logic [DATA_W-1:0] r_dout, f_dout;
    logic              r_dv, f_dv, r_empty, f_empty, r_full, f_full;
    logic              r_ae, f_ae, r_af, f_af, r_ovf, f_ovf, r_uf, f_uf;
    logic [ADDR_W:0]   r_count, f_count;

    sync_fifo_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .AF_LEVEL(AF_LEVEL),
                      .AE_LEVEL(AE_LEVEL), .FWFT(0)) u_dut_reg (
        .clk(clk), .rst(rst), .clr(clr), .push(push), .din(din), .pop(pop),
        .dout(r_dout), .dout_valid(r_dv), .empty(r_empty), .full(r_full),
        .almost_empty(r_ae), .almost_full(r_af), .count(r_count),
        .overflow(r_ovf), .underflow(r_uf)
    );

    sync_fifo_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .AF_LEVEL(AF_LEVEL),
                      .AE_LEVEL(AE_LEVEL), .FWFT(1)) u_dut_fwft (
        .clk(clk), .rst(rst), .clr(clr), .push(push), .din(din), .pop(pop),
        .dout(f_dout), .dout_valid(f_dv), .empty(f_empty), .full(f_full),
        .almost_empty(f_ae), .almost_full(f_af), .count(f_count),
        .overflow(f_ovf), .underflow(f_uf)
    );

    // ---------------- scoreboard / model ----------------
    logic [DATA_W-1:0] exp_q[$];
    logic              m_ovf  = 1'b0;
    logic              m_uf   = 1'b0;
    logic [DATA_W-1:0] m_dout = '0;
    logic              m_dv   = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_ovf  = 1'b0;
        m_uf   = 1'b0;
        m_dout = '0;
        m_dv   = 1'b0;
    endtask

    // One clock of the FIFO rules applied to the queue.
    task automatic model_cycle(input bit c, input bit ph, input bit pp,
                               input logic [DATA_W-1:0] d);
        bit pop_ok;
        bit push_ok;
        if (c) begin
            exp_q.delete();
            m_ovf = 1'b0;
            m_uf  = 1'b0;
            m_dv  = 1'b0;
            return;
        end
        pop_ok  = pp && (exp_q.size() > 0);
        push_ok = ph && ((exp_q.size() < DEPTH) || pop_ok);
        if (ph && !push_ok) m_ovf = 1'b1;
        if (pp && !pop_ok)  m_uf  = 1'b1;
        if (pop_ok) begin
            m_dout = exp_q.pop_front();
            m_dv   = 1'b1;
        end else begin
            m_dv = 1'b0;
        end
        if (push_ok) exp_q.push_back(d);
    endtask

    task automatic check_all();
        int n;
        n = exp_q.size();
        check_eq("reg_count",  32'(r_count), 32'(n));
        check_eq("reg_empty",  32'(r_empty), 32'(n == 0));
        check_eq("reg_full",   32'(r_full),  32'(n == DEPTH));
        check_eq("reg_ae",     32'(r_ae),    32'(n <= AE_LEVEL));
        check_eq("reg_af",     32'(r_af),    32'(n >= AF_LEVEL));
        check_eq("reg_ovf",    32'(r_ovf),   32'(m_ovf));
        check_eq("reg_uf",     32'(r_uf),    32'(m_uf));
        check_eq("reg_dv",     32'(r_dv),    32'(m_dv));
        check_eq("reg_dout",   32'(r_dout),  32'(m_dout));
        check_eq("fwft_count", 32'(f_count), 32'(n));
        check_eq("fwft_empty", 32'(f_empty), 32'(n == 0));
        check_eq("fwft_full",  32'(f_full),  32'(n == DEPTH));
        check_eq("fwft_ae",    32'(f_ae),    32'(n <= AE_LEVEL));
        check_eq("fwft_af",    32'(f_af),    32'(n >= AF_LEVEL));
        check_eq("fwft_ovf",   32'(f_ovf),   32'(m_ovf));
        check_eq("fwft_uf",    32'(f_uf),    32'(m_uf));
        check_eq("fwft_dv",    32'(f_dv),    32'(n != 0));
        if (n != 0) check_eq("fwft_dout", 32'(f_dout), 32'(exp_q[0]));
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_step(input bit c, input bit ph, input bit pp,
                           input logic [DATA_W-1:0] d);
        @(negedge clk);
        clr  = c;
        push = ph;
        pop  = pp;
        din  = d;
        model_cycle(c, ph, pp, d);
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Asynchronous reset asserted mid-cycle, checked before any clock edge.
    task automatic do_async_reset();
        @(negedge clk);
        clr  = 1'b0;
        push = 1'b0;
        pop  = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // Reset mid-traffic at count 5, then a fresh word round-trips.
        for (int i = 0; i < 5; i++) do_step(0, 1, 0, DATA_W'($urandom_range(0, 255)));
        do_async_reset();
        do_step(0, 1, 0, 8'h11);
        do_step(0, 0, 1, 8'h00);
        do_step(0, 0, 0, 8'h00);

        // Fill to full, rejected 9th push, drain in order.
        for (int i = 1; i <= DEPTH; i++) do_step(0, 1, 0, DATA_W'(i));
        do_step(0, 1, 0, 8'hEE);
        for (int i = 0; i < DEPTH; i++) do_step(0, 0, 1, 8'h00);
        do_step(1, 0, 0, 8'h00);

        // Full with push and pop together: no overflow, new word read last.
        for (int i = 1; i <= DEPTH; i++) do_step(0, 1, 0, DATA_W'(8'h20 + i));
        do_step(0, 1, 1, 8'hAA);
        for (int i = 0; i < DEPTH; i++) do_step(0, 0, 1, 8'h00);

        // Empty pop, push+pop on empty, clr clears underflow.
        do_step(0, 0, 1, 8'h00);
        do_step(0, 1, 1, 8'h33);
        do_step(1, 0, 0, 8'h00);

        // Word into empty FIFO visible next cycle in FWFT mode, then popped.
        do_step(0, 1, 0, 8'h5A);
        do_step(0, 0, 1, 8'h00);

        // Wrap: hover around count 3 with random push/pop.
        for (int i = 0; i < 3; i++) do_step(0, 1, 0, DATA_W'($urandom_range(0, 255)));
        for (int i = 0; i < 20; i++) begin
            bit ph;
            ph = (exp_q.size() <= 2) ? 1'b1 : (exp_q.size() >= 4) ? 1'b0 : 1'($urandom_range(0, 1));
            do_step(0, ph, !ph || 1'($urandom_range(0, 1)), DATA_W'($urandom_range(0, 255)));
        end

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            do_step($urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), DATA_W'($urandom_range(0, 255)));
        end

        // ---------------- final report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
